opb_register_simulink2ppc: RTL

Software-readable status register for a single clock domain. Fabric logic pushes a 32-bit word with a valid strobe, and the PowerPC reads it over the OPB slave bus. The register set adds a fresh/overrun handshake, an update counter and a freeze control. The block sits on the OPB bus next to the software-to-fabric registers and shares their bus timing and address-decode rules.

---
 rtl/opb_register_simulink2ppc.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/opb_register_simulink2ppc.sv
// Fabric-to-PowerPC status register on the OPB slave bus: holding register, fresh/overrun
// handshake, update counter and freeze control. SIMULINK2PPC_TIMESTAMP_EN adds a cycle-count TSTAMP.
module opb_register_simulink2ppc #(
    parameter logic [31:0] C_BASEADDR   = 32'h00000000,
    parameter logic [31:0] C_HIGHADDR   = 32'h000000FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter logic [63:0] C_FAMILY     = "virtex6"
) (
    input  logic                        OPB_Clk,
    input  logic                        OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
    input  logic                        OPB_RNW,
    input  logic                        OPB_select,
    input  logic                        OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
    output logic                        Sl_xferAck,
    output logic                        Sl_errAck,
    output logic                        Sl_retry,
    output logic                        Sl_toutSup,
    input  logic [31:0]                 user_data_in,
    input  logic                        user_valid
);

    // state  | meaning
    // S_IDLE | waiting for a decoded transfer; captures read data / write on accept
    // S_ACK  | Sl_xferAck high for this single cycle, then back to S_IDLE
    typedef enum logic {S_IDLE, S_ACK} state_t;

    state_t      state_q, state_d;
    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] data_q, data_d;
    logic [15:0] cnt_q, cnt_d;
    logic        fresh_q, fresh_d;
    logic        ovr_q, ovr_d;
    logic        freeze_q, freeze_d;
    logic [31:0] tstamp;
    logic [31:0] addr_off;
    logic [1:0]  widx;
    logic        hit, take, upd;
    logic        unused_ok;

    assign addr_off   = 32'(OPB_ABus) - C_BASEADDR;
    assign hit        = (addr_off <= (C_HIGHADDR - C_BASEADDR));
    assign widx       = OPB_ABus[28:29];
    assign upd        = user_valid & ~freeze_q;

    assign Sl_xferAck = ack_q;
    assign Sl_DBus    = rdata_q;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
    assign unused_ok  = &{1'b0, OPB_seqAddr, OPB_DBus[0:29], (C_FAMILY != 64'd0)};

    always_comb begin
        state_d  = state_q;
        ack_d    = 1'b0;
        rdata_d  = 32'h0;
        data_d   = data_q;
        cnt_d    = cnt_q;
        fresh_d  = fresh_q;
        ovr_d    = ovr_q;
        freeze_d = freeze_q;
        take     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (OPB_select && hit) begin
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                    take    = 1'b1;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (take && OPB_RNW) begin
            case (widx)
                2'd0:    rdata_d = data_q;
                2'd1:    rdata_d = {cnt_q, 14'h0, ovr_q, fresh_q};
                2'd2:    rdata_d = {31'h0, freeze_q};
                default: rdata_d = tstamp;
            endcase
            if (widx == 2'd0)
                fresh_d = 1'b0;
        end

        if (take && !OPB_RNW && (widx == 2'd2) && OPB_BE[3]) begin
            freeze_d = OPB_DBus[31];
            if (OPB_DBus[30])
                ovr_d = 1'b0;
        end

        // Update is applied last so a simultaneous set beats the read clear / overrun clear.
        if (upd) begin
            data_d  = user_data_in;
            cnt_d   = cnt_q + 16'd1;
            fresh_d = 1'b1;
            if (fresh_q)
                ovr_d = 1'b1;
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_q  <= S_IDLE;
            ack_q    <= 1'b0;
            rdata_q  <= 32'h0;
            data_q   <= 32'h0;
            cnt_q    <= 16'h0;
            fresh_q  <= 1'b0;
            ovr_q    <= 1'b0;
            freeze_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            fresh_q  <= fresh_d;
            ovr_q    <= ovr_d;
            freeze_q <= freeze_d;
        end
    end

`ifdef SIMULINK2PPC_TIMESTAMP_EN
    logic [31:0] ts_cnt_q, ts_cnt_d;
    logic [31:0] tstamp_q, tstamp_d;

    always_comb begin
        ts_cnt_d = ts_cnt_q + 32'd1;
        tstamp_d = upd ? ts_cnt_q : tstamp_q;
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            ts_cnt_q <= 32'h0;
            tstamp_q <= 32'h0;
        end else begin
            ts_cnt_q <= ts_cnt_d;
            tstamp_q <= tstamp_d;
        end
    end

    assign tstamp = tstamp_q;
`else
    assign tstamp = 32'h0;
`endif

endmodule
